// File: rtl/chk_pkg.sv
// ---------------------------------------------------------------------------
// chk_pkg
// Shared definitions for the memory result checker:
//   - chk_mode_e   : expected-sequence selector (FIBO / SORT / ZERO / reserved)
//   - chk_state_e  : checker FSM states
//   - chk_log_entry_t : one mismatch-log record {1-based index, actual data}
// The log record uses fixed maximum widths because a package cannot see the
// top-level parameters; the top module narrows/widens on access. This limits
// the optional log to DATA_W <= 64 and index widths <= 16 bits.
// ---------------------------------------------------------------------------
package chk_pkg;

  typedef enum logic [1:0] {
    CHK_FIBO = 2'd0,
    CHK_SORT = 2'd1,
    CHK_ZERO = 2'd2,
    CHK_RSVD = 2'd3
  } chk_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } chk_state_e;

  localparam int CHK_LOG_DEPTH  = 4;
  localparam int CHK_LOG_IDX_W  = 16;
  localparam int CHK_LOG_DATA_W = 64;

  typedef struct packed {
    logic [CHK_LOG_IDX_W-1:0]  idx;
    logic [CHK_LOG_DATA_W-1:0] data;
  } chk_log_entry_t;

endpackage

// File: rtl/chk_seq_gen.sv
// ---------------------------------------------------------------------------
// chk_seq_gen
// Generates the expected word e(k) for the selected mode.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : initialise to e(0) for mode_i
//   adv_i      : step from e(k) to e(k+1) using mode_i
//   mode_i     : sequence select (chk_mode_e encoding)
//   exp_o      : current expected value e(k)
// Two DATA_W registers: cur_q holds e(k), prev_q holds e(k-1) (FIBO only).
// All arithmetic wraps modulo 2^DATA_W.
// ---------------------------------------------------------------------------
module chk_seq_gen
  import chk_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int SORT_FIRST = -3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] exp_o
);

  // Sized cast of a signed int sign-extends to the full word.
  localparam logic [DATA_W-1:0] SORT_INIT = DATA_W'(SORT_FIRST);

  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] prev_q, prev_d;

  always_comb begin
    cur_d  = cur_q;
    prev_d = prev_q;
    if (load_i) begin
      prev_d = '0;
      case (mode_i)
        CHK_FIBO: cur_d = DATA_W'(1);   // prev=0 makes the first advance give e1=1
        CHK_SORT: cur_d = SORT_INIT;
        default:  cur_d = '0;
      endcase
    end else if (adv_i) begin
      case (mode_i)
        CHK_FIBO: begin
          cur_d  = cur_q + prev_q;
          prev_d = cur_q;
        end
        CHK_SORT: cur_d = cur_q + DATA_W'(1);
        default:  cur_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign exp_o = cur_q;

endmodule

// File: rtl/mem_result_checker.sv
// ---------------------------------------------------------------------------
// mem_result_checker
// On a rising CPU halt, walks NUM_WORDS words of data memory starting at
// BASE_ADDR (step ADDR_STRIDE) and compares each against a generated
// sequence (FIBO, SORT ascending from SORT_FIRST, or ZERO).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (aborts a run)
//   halt      : CPU halt; a rising edge in IDLE/DONE starts a run
//   mode      : 0 FIBO, 1 SORT, 2 ZERO, 3 reserved (immediate done, pass=0)
//   rd_addr   : memory read address (held through WAIT and CMP)
//   rd_data   : memory read data, valid RD_LAT cycles after rd_addr
//   busy      : run in progress
//   done      : run finished, held until next start or rst
//   pass      : valid with done, 1 = no mismatch
//   err_idx   : 1-based index of the first mismatch, 0 if none
//   err_cnt   : number of mismatches (saturating)
// Optional feature, macro CHK_ERRLOG_EN: 4-entry mismatch log with ports
//   log_sel (in), log_idx, log_data, log_cnt (out, combinational reads).
// Handshake: there is no valid/ready; rd_data is trusted exactly RD_LAT
// cycles after rd_addr is presented, and the compare happens in CMP.
// The FSM state is visible as state_q (chk_state_e) for checkers.
// ---------------------------------------------------------------------------
module mem_result_checker
  import chk_pkg::*;
#(
  parameter int              DATA_W      = 64,
  parameter int              ADDR_W      = 64,
  parameter int              NUM_WORDS   = 20,
  parameter longint unsigned BASE_ADDR   = 1,
  parameter longint unsigned ADDR_STRIDE = 1,
  parameter int              RD_LAT      = 0,
  parameter int              SORT_FIRST  = -3,
  parameter int              STOP_ON_ERR = 1,
  localparam int             IDX_W       = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  err_idx,
  output logic [IDX_W-1:0]  err_cnt
`ifdef CHK_ERRLOG_EN
  ,
  input  logic [1:0]        log_sel,
  output logic [IDX_W-1:0]  log_idx,
  output logic [DATA_W-1:0] log_data,
  output logic [2:0]        log_cnt
`endif
);

  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  chk_state_e        state_q;
  logic              halt_q;
  logic [1:0]        mode_q;
  logic [IDX_W-1:0]  k_q;
  logic [LAT_W-1:0]  lat_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q, done_q, pass_q;
  logic [IDX_W-1:0]  err_idx_q, err_cnt_q;

  logic              start;
  logic              mismatch;
  logic              last_word;
  logic              finish;
  logic              seq_adv;
  logic [1:0]        seq_mode;
  logic [DATA_W-1:0] seq_exp;
  logic [IDX_W-1:0]  err_cnt_inc;

  // Edges seen while a run is active are deliberately dropped.
  assign start = halt & ~halt_q & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  assign mismatch    = (state_q == ST_CMP) && (rd_data != seq_exp);
  assign last_word   = (k_q == IDX_W'(NUM_WORDS - 1));
  assign finish      = last_word | (mismatch & (STOP_ON_ERR != 0));
  assign seq_adv     = (state_q == ST_CMP) && !finish;
  // The generator loads with the live mode at start, then follows the held copy.
  assign seq_mode    = start ? mode : mode_q;
  assign err_cnt_inc = (err_cnt_q == IDX_W'(NUM_WORDS)) ? err_cnt_q : err_cnt_q + IDX_W'(1);

  chk_seq_gen #(
    .DATA_W     (DATA_W),
    .SORT_FIRST (SORT_FIRST)
  ) u_seq_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (start),
    .adv_i  (seq_adv),
    .mode_i (seq_mode),
    .exp_o  (seq_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      halt_q    <= 1'b0;
      mode_q    <= 2'd0;
      k_q       <= '0;
      lat_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_idx_q <= '0;
      err_cnt_q <= '0;
    end else begin
      halt_q <= halt;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_q    <= mode;
            k_q       <= '0;
            lat_q     <= '0;
            addr_q    <= ADDR_W'(BASE_ADDR);
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_idx_q <= '0;
            err_cnt_q <= '0;
            if (mode == CHK_RSVD) begin
              // Reserved mode: report a failed run without touching memory.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (RD_LAT == 0) begin
            state_q <= ST_CMP;
          end else begin
            lat_q   <= LAT_W'(1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q == LAT_W'(RD_LAT)) begin
            state_q <= ST_CMP;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_CMP: begin
          if (mismatch) begin
            err_cnt_q <= err_cnt_inc;
            if (err_cnt_q == '0) begin
              err_idx_q <= k_q + IDX_W'(1);
            end
          end
          if (finish) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !mismatch && (err_cnt_q == '0);
          end else begin
            state_q <= ST_ISSUE;
            k_q     <= k_q + IDX_W'(1);
            addr_q  <= addr_q + ADDR_W'(ADDR_STRIDE);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_idx = err_idx_q;
  assign err_cnt = err_cnt_q;

`ifdef CHK_ERRLOG_EN
  chk_log_entry_t log_q [CHK_LOG_DEPTH];
  logic [2:0]     log_cnt_q;

  // First four mismatches are kept in arrival order; later ones are dropped.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      log_cnt_q <= '0;
      for (int i = 0; i < CHK_LOG_DEPTH; i++) begin
        log_q[i] <= '0;
      end
    end else if (mismatch && (log_cnt_q < 3'(CHK_LOG_DEPTH))) begin
      log_q[log_cnt_q[1:0]].idx  <= CHK_LOG_IDX_W'(k_q + IDX_W'(1));
      log_q[log_cnt_q[1:0]].data <= CHK_LOG_DATA_W'(rd_data);
      log_cnt_q                  <= log_cnt_q + 3'd1;
    end
  end

  assign log_idx  = IDX_W'(log_q[log_sel].idx);
  assign log_data = DATA_W'(log_q[log_sel].data);
  assign log_cnt  = log_cnt_q;
`endif

endmodule

// File: tb/tb_mem_result_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_result_checker
// Three checker instances share clk/rst/halt/mode:
//   dut_a : defaults (RD_LAT=0, STOP_ON_ERR=1, 20 words at 1..20)
//   dut_b : RD_LAT=1 registered memory, STOP_ON_ERR=0
//   dut_c : NUM_WORDS=1, single word at 0x100
// Each has its own memory model. A table of runs gives hand-computed results.
// ---------------------------------------------------------------------------
module tb_mem_result_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       halt = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [63:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic [63:0] rd_data_a, rd_data_b, rd_data_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [4:0]  err_idx_a, err_cnt_a, err_idx_b, err_cnt_b;
  logic [0:0]  err_idx_c, err_cnt_c;
`ifdef CHK_ERRLOG_EN
  logic [1:0]  log_sel = 2'd0;
  logic [4:0]  log_idx_a, log_idx_b;
  logic [0:0]  log_idx_c;
  logic [63:0] log_data_a, log_data_b, log_data_c;
  logic [2:0]  log_cnt_a, log_cnt_b, log_cnt_c;
`endif

  mem_result_checker dut_a (
    .clk(clk), .rst(rst), .halt(halt), .mode(mode),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_idx(err_idx_a), .err_cnt(err_cnt_a)
`ifdef CHK_ERRLOG_EN
    , .log_sel(log_sel), .log_idx(log_idx_a), .log_data(log_data_a), .log_cnt(log_cnt_a)
`endif
  );

  mem_result_checker #(.RD_LAT(1), .STOP_ON_ERR(0)) dut_b (
    .clk(clk), .rst(rst), .halt(halt), .mode(mode),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_idx(err_idx_b), .err_cnt(err_cnt_b)
`ifdef CHK_ERRLOG_EN
    , .log_sel(log_sel), .log_idx(log_idx_b), .log_data(log_data_b), .log_cnt(log_cnt_b)
`endif
  );

  mem_result_checker #(.NUM_WORDS(1), .BASE_ADDR(64'h100), .ADDR_STRIDE(8)) dut_c (
    .clk(clk), .rst(rst), .halt(halt), .mode(mode),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_idx(err_idx_c), .err_cnt(err_cnt_c)
`ifdef CHK_ERRLOG_EN
    , .log_sel(log_sel), .log_idx(log_idx_c), .log_data(log_data_c), .log_cnt(log_cnt_c)
`endif
  );

  // ---------------- memory models ----------------
  logic [63:0] mem_a [32];
  logic [63:0] mem_b [32];
  logic [63:0] mem_c;

  assign rd_data_a = (rd_addr_a < 64'd32) ? mem_a[rd_addr_a[4:0]] : 64'd0;
  always @(posedge clk) rd_data_b <= (rd_addr_b < 64'd32) ? mem_b[rd_addr_b[4:0]] : 64'd0;
  assign rd_data_c = (rd_addr_c == 64'h100) ? mem_c : 64'd0;

  // Highest address dut_a presents while busy during the current run.
  logic        clr_max = 1'b0;
  logic [63:0] max_addr_a;
  always @(posedge clk) begin
    if (clr_max) max_addr_a <= 64'd0;
    else if (busy_a && rd_addr_a > max_addr_a) max_addr_a <= rd_addr_a;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Fill memories with the correct sequence for m, then overwrite the
  // 1-based words bad0/bad1 (0 = unused) with 99.
  task automatic load_mem(input logic [1:0] m, input int bad0, input int bad1);
    logic [63:0] f0, f1, v;
    f0 = 64'd0;
    f1 = 64'd1;
    for (int w = 1; w <= 20; w++) begin
      case (m)
        2'd0: v = f1;
        2'd1: v = 64'(longint'(-3 + w - 1));
        default: v = 64'd0;
      endcase
      if (w == 1) mem_c = (bad0 == 1) ? 64'd99 : v;
      if (w == bad0 || w == bad1) v = 64'd99;
      mem_a[w] = v;
      mem_b[w] = v;
      {f0, f1} = {f1, f0 + f1};
    end
  endtask

  // Raise halt, sample right after the start edge, then count edges until
  // each instance shows done (-1 if never within the budget).
  task automatic start_and_wait(output int ca, output int cb, output int cc,
                                output logic busy0, output logic [4:0] cnt0);
    ca = -1; cb = -1; cc = -1;
    @(negedge clk);
    halt = 1'b1;
    clr_max = 1'b1;
    @(posedge clk);
    #1;
    clr_max = 1'b0;
    busy0 = busy_a;
    cnt0  = err_cnt_a;
    for (int n = 0; n <= 200; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (ca < 0 && done_a) ca = n;
      if (cb < 0 && done_b) cb = n;
      if (cc < 0 && done_c) cc = n;
      if (ca >= 0 && cb >= 0 && cc >= 0) break;
    end
    @(negedge clk);
    halt = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] mode;
    int   bad0, bad1;
    logic pass_a; int idx_a, cnt_a, cyc_a, max_a;
    logic pass_b; int idx_b, cnt_b, cyc_b;
    logic pass_c; int idx_c, cyc_c;
    logic busy0;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int ca, cb, cc;
    logic b0;
    logic [4:0] c0;
    bit hit;

    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 64'd0;
      mem_b[i] = 64'd0;
    end
    mem_c = 64'd0;

    //          mode  bad0 bad1  pa ia ca cyc max  pb ib cb cyc  pc ic cyc busy0
    vecs[0] = '{2'd0,  0,  0,   1, 0, 0, 40, 20,  1, 0, 0, 60,  1, 0, 2,  1};
    vecs[1] = '{2'd0,  7,  0,   0, 7, 1, 14,  7,  0, 7, 1, 60,  1, 0, 2,  1};
    vecs[2] = '{2'd1,  3,  9,   0, 3, 1,  6,  3,  0, 3, 2, 60,  1, 0, 2,  1};
    vecs[3] = '{2'd2,  1, 20,   0, 1, 1,  2,  1,  0, 1, 2, 60,  0, 1, 2,  1};
    vecs[4] = '{2'd2,  0,  0,   1, 0, 0, 40, 20,  1, 0, 0, 60,  1, 0, 2,  1};
    vecs[5] = '{2'd1, 20,  0,   0,20, 1, 40, 20,  0,20, 1, 60,  1, 0, 2,  1};
    vecs[6] = '{2'd3,  0,  0,   0, 0, 0,  0,  0,  0, 0, 0,  0,  0, 0, 0,  0};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst done", 64'(done_a), 64'd0);
    check("rst pass", 64'(pass_a), 64'd0);
    check("rst err_idx", 64'(err_idx_a), 64'd0);
    check("rst err_cnt", 64'(err_cnt_a), 64'd0);
    check("rst rd_addr", rd_addr_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- table-driven runs ----
    for (int i = 0; i < 7; i++) begin
      load_mem(vecs[i].mode, vecs[i].bad0, vecs[i].bad1);
      mode = vecs[i].mode;
      start_and_wait(ca, cb, cc, b0, c0);
      check($sformatf("v%0d busy after start", i), 64'(b0), 64'(vecs[i].busy0));
      check($sformatf("v%0d err_cnt cleared", i), 64'(c0), 64'd0);
      check($sformatf("v%0d a cycles", i), 64'(ca), 64'(vecs[i].cyc_a));
      check($sformatf("v%0d a pass", i), 64'(pass_a), 64'(vecs[i].pass_a));
      check($sformatf("v%0d a err_idx", i), 64'(err_idx_a), 64'(vecs[i].idx_a));
      check($sformatf("v%0d a err_cnt", i), 64'(err_cnt_a), 64'(vecs[i].cnt_a));
      check($sformatf("v%0d a max addr", i), max_addr_a, 64'(vecs[i].max_a));
      check($sformatf("v%0d a busy at end", i), 64'(busy_a), 64'd0);
      check($sformatf("v%0d b cycles", i), 64'(cb), 64'(vecs[i].cyc_b));
      check($sformatf("v%0d b pass", i), 64'(pass_b), 64'(vecs[i].pass_b));
      check($sformatf("v%0d b err_idx", i), 64'(err_idx_b), 64'(vecs[i].idx_b));
      check($sformatf("v%0d b err_cnt", i), 64'(err_cnt_b), 64'(vecs[i].cnt_b));
      check($sformatf("v%0d c cycles", i), 64'(cc), 64'(vecs[i].cyc_c));
      check($sformatf("v%0d c pass", i), 64'(pass_c), 64'(vecs[i].pass_c));
      check($sformatf("v%0d c err_idx", i), 64'(err_idx_c), 64'(vecs[i].idx_c));
    end

    // ---- rst pulsed mid-run at word 5, then a clean run ----
    load_mem(2'd0, 0, 0);
    mode = 2'd0;
    @(negedge clk);
    halt = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (rd_addr_a == 64'd5) begin
        hit = 1'b1;
        break;
      end
    end
    check("midrst reached word 5", 64'(hit), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    halt = 1'b0;
    @(posedge clk);
    #1;
    check("midrst busy", 64'(busy_a), 64'd0);
    check("midrst done", 64'(done_a), 64'd0);
    check("midrst rd_addr", rd_addr_a, 64'd0);
    check("midrst err_cnt b", 64'(err_cnt_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_and_wait(ca, cb, cc, b0, c0);
    check("post-rst cycles", 64'(ca), 64'd40);
    check("post-rst pass", 64'(pass_a), 64'd1);
    check("post-rst err_idx", 64'(err_idx_a), 64'd0);

    // ---- halt toggled while busy, then reserved mode ----
    load_mem(2'd0, 0, 0);
    mode = 2'd0;
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
    ca = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n >= 3 && n <= 10) halt = ~halt;   // several rising edges mid-run
      if (n == 11) halt = 1'b0;
      @(posedge clk);
      #1;
      if (done_a) begin
        ca = n;
        break;
      end
    end
    check("toggle cycles", 64'(ca), 64'd40);
    check("toggle pass", 64'(pass_a), 64'd1);
    repeat (5) @(negedge clk);
    mode = 2'd3;
    start_and_wait(ca, cb, cc, b0, c0);
    check("mode3 done", 64'(done_a), 64'd1);
    check("mode3 pass", 64'(pass_a), 64'd0);
    check("mode3 busy", 64'(b0), 64'd0);

`ifdef CHK_ERRLOG_EN
    // ---- mismatch log: six errors, first four kept ----
    load_mem(2'd2, 0, 0);
    for (int j = 0; j < 6; j++) mem_b[2 + 2 * j] = 64'(102 + 2 * j);
    mode = 2'd2;
    start_and_wait(ca, cb, cc, b0, c0);
    check("log err_cnt", 64'(err_cnt_b), 64'd6);
    check("log err_idx", 64'(err_idx_b), 64'd2);
    check("log cnt", 64'(log_cnt_b), 64'd4);
    for (int j = 0; j < 4; j++) begin
      log_sel = 2'(j);
      #1;
      check($sformatf("log idx %0d", j), 64'(log_idx_b), 64'(2 + 2 * j));
      check($sformatf("log data %0d", j), log_data_b, 64'(102 + 2 * j));
    end
`endif

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
